// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the load/store unit.
//   mem_funct3_e : access size encodings (loads and stores share B/H/W codes)
//   lsu_state_e  : control FSM states
//   lsu_req_t    : registered copy of an accepted request
//   access_fault : misaligned / out-of-range / illegal access check
package load_store_unit_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } mem_funct3_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MERGE,
        ST_WRITE,
        ST_RESP
    } lsu_state_e;

    typedef struct packed {
        logic              store;
        logic [2:0]        funct3;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } lsu_req_t;

    // True when the access must be rejected without a memory cycle.
    function automatic logic access_fault(
        input logic              store,
        input logic [2:0]        funct3,
        input logic [ADDR_W-1:0] addr,
        input int unsigned       mem_words
    );
        logic illegal;
        logic misaligned;
        logic out_of_range;
        illegal      = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (store && funct3[2]);
        misaligned   = ((funct3 == F3_H || funct3 == F3_HU) && addr[0]) ||
                       ((funct3 == F3_W) && (addr[1:0] != 2'b00));
        out_of_range = 32'(addr[ADDR_W-1:2]) >= 32'(mem_words);
        return illegal || misaligned || out_of_range;
    endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Combinational lane logic shared by the load and merge paths.
//   word        : memory word being read
//   addr_lo     : byte offset within the word
//   funct3      : access size / extension
//   wdata       : right-aligned store data
//   load_value  : extracted and sign/zero-extended load result
//   merged_word : word with the addressed lane replaced by wdata (wdata for W)
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [DATA_W-1:0] word,
    input  logic [1:0]        addr_lo,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_value,
    output logic [DATA_W-1:0] merged_word
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Lane extraction and extension for loads.
    always_comb begin
        lane_byte  = word[{addr_lo, 3'b000} +: 8];
        lane_half  = word[{addr_lo[1], 4'b0000} +: 16];
        load_value = '0;
        case (funct3)
            F3_B:    load_value = {{24{lane_byte[7]}}, lane_byte};
            F3_BU:   load_value = {24'h000000, lane_byte};
            F3_H:    load_value = {{16{lane_half[15]}}, lane_half};
            F3_HU:   load_value = {16'h0000, lane_half};
            F3_W:    load_value = word;
            default: load_value = '0;
        endcase
    end

    // Read-modify-write merge for stores.
    always_comb begin
        merged_word = word;
        case (funct3)
            F3_B:    merged_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            F3_H:    merged_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            F3_W:    merged_word = wdata;
            default: merged_word = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store initiator for a word-organised data memory.
//   clk, reset                : clock, synchronous active-high reset
//   req_*                     : one request at a time, accepted when req_ready
//   resp_valid/rdata/fault    : one-cycle completion pulse with result
//   mem_idx / mem_write_*     : word address and write strobe to memory
//   mem_read_data             : combinational read of mem_idx
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_fault,
    output logic [ADDR_W-1:0] mem_idx,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_enable,
    input  logic [DATA_W-1:0] mem_read_data
);

    lsu_state_e        state;
    lsu_state_e        state_next;
    lsu_req_t          req_q;
    logic [DATA_W-1:0] merged_q;
    logic [DATA_W-1:0] load_value;
    logic [DATA_W-1:0] merged_word;
    logic              accept_fault;

    assign accept_fault = access_fault(req_store, req_funct3, req_addr, MEM_WORDS);

    lsu_lane_align u_lane_align (
        .word        (mem_read_data),
        .addr_lo     (req_q.addr[1:0]),
        .funct3      (req_q.funct3),
        .wdata       (req_q.wdata),
        .load_value  (load_value),
        .merged_word (merged_word)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and memory-side / handshake outputs.
    always_comb begin
        state_next       = state;
        req_ready        = 1'b0;
        resp_valid       = 1'b0;
        mem_idx          = '0;
        mem_write_data   = '0;
        mem_write_enable = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (accept_fault) begin
                        state_next = ST_RESP;
                    end else if (!req_store) begin
                        state_next = ST_LOAD;
                    end else if (req_funct3 == F3_W) begin
                        state_next = ST_WRITE;
                    end else begin
                        state_next = ST_MERGE;
                    end
                end
            end
            ST_LOAD: begin
                mem_idx    = {req_q.addr[ADDR_W-1:2], 2'b00};
                state_next = ST_RESP;
            end
            ST_MERGE: begin
                mem_idx    = {req_q.addr[ADDR_W-1:2], 2'b00};
                state_next = ST_WRITE;
            end
            ST_WRITE: begin
                mem_idx          = {req_q.addr[ADDR_W-1:2], 2'b00};
                mem_write_data   = merged_q;
                // Reset in this cycle must cancel the commit at the coming edge.
                mem_write_enable = req_q.store && !reset;
                state_next       = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Request capture, merged word and response registers; response values
    // only change on the edge that enters RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_q      <= '0;
            merged_q   <= '0;
            resp_rdata <= '0;
            resp_fault <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_q    <= '{store: req_store, funct3: req_funct3,
                                      addr: req_addr, wdata: req_wdata};
                        merged_q <= req_wdata;
                        if (accept_fault) begin
                            resp_rdata <= '0;
                            resp_fault <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    resp_rdata <= load_value;
                    resp_fault <= 1'b0;
                end
                ST_MERGE: merged_q <= merged_word;
                ST_WRITE: begin
                    resp_rdata <= '0;
                    resp_fault <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    localparam int unsigned MW = 128;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_idx;
    logic [31:0] mem_write_data;
    logic        mem_write_enable;
    logic [31:0] mem_read_data;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.MEM_WORDS(MW)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_store        (req_store),
        .req_funct3       (req_funct3),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_fault       (resp_fault),
        .mem_idx          (mem_idx),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_read_data    (mem_read_data)
    );

    always #5 clk = ~clk;

    // Physical memory seen by the DUT, with a bench back door for preloading.
    logic        bd_we = 1'b0;
    logic [6:0]  bd_idx;
    logic [31:0] bd_data;
    logic [31:0] phys [MW];
    logic [31:0] model [MW];

    always @(posedge clk) begin
        if (bd_we) phys[bd_idx] <= bd_data;
        else if (mem_write_enable) phys[mem_idx[8:2]] <= mem_write_data;
    end
    assign mem_read_data = phys[mem_idx[8:2]];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic backdoor(input int i, input logic [31:0] v);
        @(negedge clk);
        bd_we = 1'b1; bd_idx = 7'(i); bd_data = v;
        @(negedge clk);
        bd_we = 1'b0;
        model[i] = v;
    endtask

    // Reference rules written from the access definitions.
    function automatic logic ref_fault(input logic st, input logic [2:0] f3, input logic [31:0] a);
        int  f;
        bit  legal, mis, oor;
        f     = int'(f3);
        legal = st ? (f <= 2) : (f == 0 || f == 1 || f == 2 || f == 4 || f == 5);
        mis   = ((f == 1 || f == 5) && (a % 2 != 0)) || (f == 2 && (a % 4 != 0));
        oor   = (a / 4) >= MW;
        return !legal || mis || oor;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3, input int off);
        int b, h;
        b = int'((w >> (8 * off)) & 32'hFF);
        h = int'((w >> (16 * (off / 2))) & 32'hFFFF);
        case (f3)
            3'd0:    return (b >= 128) ? 32'(b - 256) : 32'(b);
            3'd4:    return 32'(b);
            3'd1:    return (h >= 32768) ? 32'(h - 65536) : 32'(h);
            3'd5:    return 32'(h);
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [2:0] f3, input int off,
                                              input logic [31:0] wd);
        int sh;
        case (f3)
            3'd0: begin sh = 8 * off;        return (w & ~(32'hFF << sh))   | ((wd & 32'hFF) << sh); end
            3'd1: begin sh = 16 * (off / 2); return (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh); end
            default: return wd;
        endcase
    endfunction

    // Issue one request and observe until its response (bounded).
    task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input bit junk,
                           output logic [31:0] rd, output logic flt, output int lat,
                           output int wr, output logic hs);
        @(negedge clk);
        hs = req_ready;
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        rd = '0; flt = 1'b0; lat = -1; wr = 0;
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1 && req_ready) hs = 1'b0;
            if (junk) begin
                req_valid = 1'b1; req_store = 1'($urandom); req_funct3 = 3'($urandom);
                req_addr = $urandom; req_wdata = $urandom;
            end else begin
                req_valid = 1'b0;
            end
            if (mem_write_enable) wr++;
            if (resp_valid) begin
                lat = k; rd = resp_rdata; flt = resp_fault;
                break;
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
        if (resp_valid || !req_ready) hs = 1'b0;
    endtask

    task automatic run_check(input string tag, input logic st, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd, input bit junk,
                             input logic [31:0] e_rd, input logic e_flt, input int e_lat, input int e_wr);
        logic [31:0] rd;
        logic        flt, hs;
        int          lat, wr;
        run_req(st, f3, a, wd, junk, rd, flt, lat, wr, hs);
        chk({tag, ".latency"}, 32'(lat), 32'(e_lat));
        chk({tag, ".rdata"}, rd, e_rd);
        chk({tag, ".fault"}, 32'(flt), 32'(e_flt));
        chk({tag, ".writes"}, 32'(wr), 32'(e_wr));
        chk({tag, ".handshake"}, 32'(hs), 32'd1);
    endtask

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] e_rd;
        logic        e_flt;
        int          e_lat;
        int          e_wr;
        bit          chk_mem;
        int          mem_w;
        logic [31:0] mem_v;
    } vec_t;

    vec_t vecs [13];

    initial begin
        logic [31:0] rd;
        logic        flt, hs;
        int          lat, wr;
        logic [31:0] orig;

        reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0;

        for (int i = 0; i < int'(MW); i++) backdoor(i, $urandom);
        backdoor(1, 32'h8081_F27F);
        backdoor(2, 32'h1122_3344);

        @(negedge clk);
        chk("reset.req_ready", 32'(req_ready), 32'd1);
        chk("reset.resp_valid", 32'(resp_valid), 32'd0);
        chk("reset.resp_rdata", resp_rdata, 32'd0);
        chk("reset.resp_fault", 32'(resp_fault), 32'd0);
        chk("reset.mem_idx", mem_idx, 32'd0);
        chk("reset.mem_write_data", mem_write_data, 32'd0);
        chk("reset.mem_write_enable", 32'(mem_write_enable), 32'd0);
        reset = 1'b0;

        //          st    f3    addr         wdata          e_rd          flt  lat wr chk w  value
        vecs[0]  = '{1'b0, 3'd0, 32'd4,   32'd0,         32'h0000_007F, 1'b0, 2, 0, 0, 0, 32'd0};
        vecs[1]  = '{1'b0, 3'd0, 32'd7,   32'd0,         32'hFFFF_FF80, 1'b0, 2, 0, 0, 0, 32'd0};
        vecs[2]  = '{1'b0, 3'd4, 32'd7,   32'd0,         32'h0000_0080, 1'b0, 2, 0, 0, 0, 32'd0};
        vecs[3]  = '{1'b0, 3'd1, 32'd6,   32'd0,         32'hFFFF_8081, 1'b0, 2, 0, 0, 0, 32'd0};
        vecs[4]  = '{1'b0, 3'd5, 32'd6,   32'd0,         32'h0000_8081, 1'b0, 2, 0, 0, 0, 32'd0};
        vecs[5]  = '{1'b0, 3'd2, 32'd4,   32'd0,         32'h8081_F27F, 1'b0, 2, 0, 0, 0, 32'd0};
        vecs[6]  = '{1'b1, 3'd0, 32'd9,   32'hDEAD_BEAA, 32'd0,         1'b0, 3, 1, 1, 2, 32'h1122_AA44};
        vecs[7]  = '{1'b1, 3'd1, 32'd10,  32'h0000_5566, 32'd0,         1'b0, 3, 1, 1, 2, 32'h5566_AA44};
        vecs[8]  = '{1'b1, 3'd2, 32'd12,  32'hCAFE_F00D, 32'd0,         1'b0, 2, 1, 1, 3, 32'hCAFE_F00D};
        vecs[9]  = '{1'b0, 3'd2, 32'd6,   32'd0,         32'd0,         1'b1, 1, 0, 0, 0, 32'd0};
        vecs[10] = '{1'b1, 3'd1, 32'd5,   32'h1234_5678, 32'd0,         1'b1, 1, 0, 1, 1, 32'h8081_F27F};
        vecs[11] = '{1'b0, 3'd0, 32'd512, 32'd0,         32'd0,         1'b1, 1, 0, 0, 0, 32'd0};
        vecs[12] = '{1'b1, 3'd4, 32'd0,   32'hFFFF_FFFF, 32'd0,         1'b1, 1, 0, 0, 0, 32'd0};

        for (int i = 0; i < 13; i++) begin
            run_check($sformatf("vec[%0d]", i), vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                      1'b0, vecs[i].e_rd, vecs[i].e_flt, vecs[i].e_lat, vecs[i].e_wr);
            if (vecs[i].chk_mem) begin
                chk($sformatf("vec[%0d].mem", i), phys[vecs[i].mem_w], vecs[i].mem_v);
                model[vecs[i].mem_w] = vecs[i].mem_v;
            end
        end

        // Reset asserted during the WRITE cycle of a byte store.
        orig = model[0];
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd0; req_addr = 32'd0;
        req_wdata = ~orig;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("rstwr.we_before", 32'(mem_write_enable), 32'd1);
        reset = 1'b1;
        #1;
        chk("rstwr.we_masked", 32'(mem_write_enable), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        chk("rstwr.req_ready", 32'(req_ready), 32'd1);
        chk("rstwr.resp_valid", 32'(resp_valid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rstwr.no_resp[%0d]", k), 32'(resp_valid), 32'd0);
        end
        chk("rstwr.mem", phys[0], orig);
        run_check("rstwr.lw", 1'b0, 3'd2, 32'd0, 32'd0, 1'b0, orig, 1'b0, 2, 0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 300; n++) begin
            logic        st;
            logic [2:0]  f3;
            logic [31:0] a, wd, e_rd;
            logic        e_flt;
            int          e_lat, e_wr;
            st = 1'($urandom);
            f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) f3 = {1'b1, 2'($urandom_range(0, 1))};
            if ($urandom_range(0, 15) == 0) a = $urandom;
            else a = 32'($urandom_range(0, MW - 1) * 4 + $urandom_range(0, 3));
            wd = $urandom;
            e_flt = ref_fault(st, f3, a);
            e_rd  = '0;
            e_wr  = 0;
            if (e_flt) e_lat = 1;
            else if (!st) begin
                e_lat = 2;
                e_rd  = ref_load(model[a / 4], f3, int'(a % 4));
            end else begin
                e_lat = (f3 == 3'd2) ? 2 : 3;
                e_wr  = 1;
                model[a / 4] = ref_store(model[a / 4], f3, int'(a % 4), wd);
            end
            run_check($sformatf("rnd[%0d]", n), st, f3, a, wd, bit'($urandom_range(0, 1)),
                      e_rd, e_flt, e_lat, e_wr);
            if (st && !e_flt) chk($sformatf("rnd[%0d].mem", n), phys[a / 4], model[a / 4]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
